// File: rtl/pipe_stage_reg_pkg.sv
// Shared lc3b pipeline types: control-word width and the ID/EX payload layout.
// Stages pass these widths to pipe_stage_reg as CTRL_WIDTH / DATA_WIDTH.
package lc3b_types;

  localparam int LC3B_CTRL_WIDTH = 32;

  typedef logic [LC3B_CTRL_WIDTH-1:0] lc3b_control_word;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] srcA;
    logic [15:0] srcB;
    logic [15:0] imm;
    logic [15:0] offset;
    logic [15:0] trapVec;
    logic [15:0] nextPc;
    logic [2:0]  sr1Idx;
    logic [2:0]  sr2Idx;
    logic [2:0]  drIdx;
    logic [22:0] spare;
  } lc3b_id_ex_payload;

  localparam int LC3B_ID_EX_WIDTH = $bits(lc3b_id_ex_payload);

  // Held-entry count from the slot valid bits.
  function automatic logic [1:0] occupancyCount(input logic mValid, input logic sValid);
    return {1'b0, mValid} + {1'b0, sValid};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry (valid/ctrl/data) with synchronous load and clear.
// Priority: reset > clear > load; clear zeroes the control word but keeps data.
module pipe_slot #(
  parameter int CTRL_WIDTH = 32,
  parameter int DATA_WIDTH = 160
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and bubble masking.
// Define PIPE_STAGE_SKID_EN to add a skid slot so in_ready comes only from flops.
module pipe_stage_reg
  import lc3b_types::*;
#(
  parameter int CTRL_WIDTH = LC3B_CTRL_WIDTH,
  parameter int DATA_WIDTH = LC3B_ID_EX_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  logic                  mValid;
  logic [CTRL_WIDTH-1:0] mCtrl;
  logic [DATA_WIDTH-1:0] mData;
  logic                  mLoad, mClear;
  logic [CTRL_WIDTH-1:0] mLoadCtrl;
  logic [DATA_WIDTH-1:0] mLoadData;
  logic                  doAccept, doRelease;

  assign doAccept  = in_valid & in_ready;
  assign doRelease = mValid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic                  sValid, sLoad, sClear, mHeld;
  logic [CTRL_WIDTH-1:0] sCtrl;
  logic [DATA_WIDTH-1:0] sData;

  // While S is full upstream is stalled, so an M refill from S never races an accept.
  assign in_ready  = ~reset & ~sValid;
  assign mHeld     = mValid & ~out_ready;
  assign sLoad     = doAccept & mHeld;
  assign sClear    = flush | (doRelease & sValid);
  assign mLoad     = (doRelease & sValid) | (doAccept & ~mHeld);
  assign mLoadCtrl = sValid ? sCtrl : in_ctrl;
  assign mLoadData = sValid ? sData : in_data;
  assign mClear    = flush | (doRelease & ~mLoad);
  assign occupancy = occupancyCount(mValid, sValid);

  pipe_slot #(
    .CTRL_WIDTH(CTRL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) sSlot (
    .clk    (clk),
    .reset  (reset),
    .clear_i(sClear),
    .load_i (sLoad),
    .ctrl_i (in_ctrl),
    .data_i (in_data),
    .valid_o(sValid),
    .ctrl_o (sCtrl),
    .data_o (sData)
  );
`else
  assign in_ready  = ~reset & (~mValid | out_ready);
  assign mLoad     = doAccept;
  assign mLoadCtrl = in_ctrl;
  assign mLoadData = in_data;
  assign mClear    = flush | (doRelease & ~doAccept);
  assign occupancy = occupancyCount(mValid, 1'b0);
`endif

  pipe_slot #(
    .CTRL_WIDTH(CTRL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) mSlot (
    .clk    (clk),
    .reset  (reset),
    .clear_i(mClear),
    .load_i (mLoad),
    .ctrl_i (mLoadCtrl),
    .data_i (mLoadData),
    .valid_o(mValid),
    .ctrl_o (mCtrl),
    .data_o (mData)
  );

  // Bubbles present a zero control word so downstream decodes a NOP.
  assign out_valid = mValid;
  assign out_ctrl  = mValid ? mCtrl : '0;
  assign out_data  = mData;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the lc3b pipeline. It generalises the fixed-field stage latches into one block with a `valid`/`ready` handshake, backpressure, flush, and bubble insertion. Every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it, with a different payload width each time. An optional skid slot breaks the combinational `ready` path between stages.

## Interface
Parameters:
- `CTRL_WIDTH`, default 32: width of the control-word field. This field is zeroed for bubbles, flushes and reset.
- `DATA_WIDTH`, default 160: width of the data payload (PC, instruction, operands, immediates, register indices), concatenated by the instantiating stage.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: synchronous kill of every held entry.
- `in_valid` input 1: upstream presents an entry.
- `in_ready` output 1: block accepts an entry this cycle.
- `in_ctrl` input CTRL_WIDTH: upstream control word.
- `in_data` input DATA_WIDTH: upstream payload.
- `out_valid` output 1: downstream entry is valid.
- `out_ready` input 1: downstream consumes this cycle.
- `out_ctrl` output CTRL_WIDTH: registered control word. It is 0 whenever `out_valid` is 0.
- `out_data` output DATA_WIDTH: registered payload.
- `occupancy` output 2: number of held entries (0..1, or 0..2 with the skid slot).

## Operation
- Accept: `in_valid && in_ready` at the clock edge. Release: `out_valid && out_ready` at the clock edge.
- Main slot M drives the outputs directly. There is no combinational path from `in_*` to `out_*`.
- Single-slot mode: `in_ready = ~M.valid | out_ready`.
  - An accept loads M.
  - A release with no accept clears M.valid.
  - A release and an accept in the same cycle replace M with the new entry.
- Skid mode:
  - `in_ready = ~S.valid`, taken from a flop.
  - An accept while M is empty, or while M releases in the same cycle, goes to M.
  - An accept while M is held (`M.valid && ~out_ready`) goes to S.
  - When M releases and S is valid, M takes S and S clears.
  - Order is always preserved: S is never bypassed.
- Bubble: `out_ctrl` is masked to 0 when `out_valid` is 0, so a downstream decoder sees a NOP. `out_data` is don't-care in that state.
- Flush:
  - Clears M.valid and S.valid, and zeroes the stored control words.
  - An accept presented in the flush cycle is dropped.
  - A release in the flush cycle still counts as consumed downstream, because the outputs were valid before the edge.
  - Flush outranks accept and release. Reset outranks flush.
- Reset:
  - While `reset` is high: `in_ready` = 0, and no accept occurs.
  - After the reset edge: `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0, `occupancy` = 0.
  - From the first cycle after reset deasserts: `in_ready` = 1.
  - Reset mid-stream discards all held entries with no partial update.
- Stall by upstream is modelled as `in_valid` = 0. The block never invents entries.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 entry per cycle while `out_ready` stays high, in both modes.
- Single-slot mode: `in_ready` depends combinationally on `out_ready`.
- Skid mode: `in_ready` depends only on flops. The cost is one extra buffered entry after `out_ready` falls.
- `occupancy` is registered and updates on the same edge as the slots.

## Configuration
- Macro: `PIPE_STAGE_SKID_EN`.
- Defined: the skid slot S is built, `in_ready` is registered, and `occupancy` ranges 0..2.
- Undefined: single-slot mode, S logic is not synthesised, and `occupancy[1]` is tied to 0.

## Structure
- The `lc3b_types` package carries the concrete payload widths: `lc3b_control_word` bit width, and a packed `lc3b_id_ex_payload` struct with its `$bits` constant. Stages pass these as `CTRL_WIDTH`/`DATA_WIDTH`.
- Sub-module `pipe_slot`: one valid/ctrl/data entry with synchronous load and clear. It is instantiated once for M and once more for S under `PIPE_STAGE_SKID_EN`.

## Test plan
- Reset then stream: `reset` for 2 cycles, then 4 entries with ctrl 0x11..0x14 and `out_ready` = 1 → outputs appear one cycle after each accept, in order. `in_ready` stays 1 throughout.
- Backpressure: accept ctrl 0xA1, then hold `out_ready` = 0 for 3 cycles with `in_valid` = 1 and ctrl 0xA2.
  - Single-slot mode: `in_ready` = 0 and `out_ctrl` stays 0xA1.
  - Skid mode: 0xA2 is captured, `occupancy` = 2, `in_ready` = 0.
  - After `out_ready` rises, 0xA1 then 0xA2 are delivered.
- Flush with collision: `occupancy` = 2, assert `flush` with `in_valid` = 1 and ctrl 0xFF → next cycle `out_valid` = 0, `out_ctrl` = 0, `occupancy` = 0, and 0xFF is never output.
- Bubble: `in_valid` = 0 for 2 cycles mid-stream → `out_valid` = 0 and `out_ctrl` = 0 for exactly 2 cycles.
- Reset priority: `reset` and `flush` high together with `in_valid` = 1 → `in_ready` = 0 that cycle, and all outputs are 0 after the edge.
- Wide payload: `DATA_WIDTH` = 160 with pattern 0xDEAD…BEEF → `out_data` is bit-exact after one cycle.
